// File: rtl/pwm_cap_pkg.sv
// Shared state type and default sizing for the PWM capture block.
// PWM_CAPTURE_FILTER_EN adds the debounce length default.
package pwm_cap_pkg;

   typedef enum logic [1:0] {
      IDLE,
      HIGH,
      LOW
   } capState_t;

   localparam int CNT_W_DEF = 20;

   // Matched to the LED breath PWM frame, so a stuck pin is flagged within about one frame.
   localparam int unsigned MAX_PERIOD_DEF = 1_000_000;

`ifdef PWM_CAPTURE_FILTER_EN
   localparam int FILT_LEN_DEF = 4;
`endif

endpackage

// File: rtl/pwm_in_cond.sv
// Input conditioning: 2-flop synchronizer, debounce when PWM_CAPTURE_FILTER_EN is defined,
// then a registered edge detector producing single-cycle rise/fall strobes.
module pwm_in_cond
   import pwm_cap_pkg::*;
`ifdef PWM_CAPTURE_FILTER_EN
   #(
      parameter int FILT_LEN = FILT_LEN_DEF
   )
`endif
   (
      input  logic i_clk,
      input  logic i_rst_n,
      input  logic i_pwm,
      output logic o_level,
      output logic o_rise,
      output logic o_fall
   );

   logic r_sync1;
   logic r_sync2;
   logic r_prev;
   logic r_rise;
   logic r_fall;
   logic w_level;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= i_pwm;
         r_sync2 <= r_sync1;
      end
   end

`ifdef PWM_CAPTURE_FILTER_EN
   localparam int FW = $clog2(FILT_LEN + 1);

   logic [FW-1:0] r_filtCnt;
   logic          r_filt;

   // The filtered level flips only once FILT_LEN consecutive samples disagree with it.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_filtCnt <= '0;
         r_filt    <= 1'b0;
      end else if (r_sync2 == r_filt) begin
         r_filtCnt <= '0;
      end else if (r_filtCnt == FW'(FILT_LEN - 1)) begin
         r_filt    <= r_sync2;
         r_filtCnt <= '0;
      end else begin
         r_filtCnt <= r_filtCnt + FW'(1);
      end
   end

   assign w_level = r_filt;
`else
   assign w_level = r_sync2;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_prev <= 1'b0;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_prev <= w_level;
         r_rise <= w_level & ~r_prev;
         r_fall <= ~w_level & r_prev;
      end
   end

   assign o_level = r_prev;
   assign o_rise  = r_rise;
   assign o_fall  = r_fall;

endmodule

// File: rtl/pwm_capture.sv
// PWM period/high-time meter: reports both in clock cycles once per complete PWM cycle.
// PWM_CAPTURE_FILTER_EN inserts a FILT_LEN-sample debounce in the input path.
module pwm_capture
   import pwm_cap_pkg::*;
   #(
      parameter int          CNT_W      = CNT_W_DEF,
      parameter int unsigned MAX_PERIOD = MAX_PERIOD_DEF
`ifdef PWM_CAPTURE_FILTER_EN
      ,
      parameter int          FILT_LEN   = FILT_LEN_DEF
`endif
   )
   (
      input  logic             s_clk,
      input  logic             s_rst,
      input  logic             pwm_in,
      output logic [CNT_W-1:0] period,
      output logic [CNT_W-1:0] high_time,
      output logic             meas_valid,
      output logic             timeout,
      output logic             pwm_level
   );

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PERIOD);

   capState_t        r_state;
   capState_t        w_stateNext;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cntNext;
   logic [CNT_W-1:0] r_hcnt;
   logic [CNT_W-1:0] w_hcntNext;
   logic [CNT_W-1:0] r_period;
   logic [CNT_W-1:0] r_highTime;
   logic             r_measValid;
   logic             r_timeout;
   logic             w_report;
   logic             w_timeout;
   logic             w_level;
   logic             w_rise;
   logic             w_fall;

   pwm_in_cond
`ifdef PWM_CAPTURE_FILTER_EN
      #(.FILT_LEN(FILT_LEN))
`endif
      u_cond (
         .i_clk   (s_clk),
         .i_rst_n (s_rst),
         .i_pwm   (pwm_in),
         .o_level (w_level),
         .o_rise  (w_rise),
         .o_fall  (w_fall)
      );

   always_ff @(posedge s_clk or negedge s_rst) begin
      if (!s_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Edges take priority over the timeout check; the counter restarts at 1 after every timeout.
   always_comb begin
      w_stateNext = r_state;
      w_cntNext   = (r_cnt == MAX_CNT) ? r_cnt : r_cnt + CNT_W'(1);
      w_hcntNext  = r_hcnt;
      w_report    = 1'b0;
      w_timeout   = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_rise) begin
               w_cntNext   = CNT_W'(1);
               w_stateNext = HIGH;
            end else if (r_cnt == MAX_CNT) begin
               w_timeout = 1'b1;
               w_cntNext = CNT_W'(1);
            end
         end
         HIGH: begin
            if (w_fall) begin
               w_hcntNext  = r_cnt;
               w_stateNext = LOW;
            end else if (r_cnt == MAX_CNT) begin
               w_timeout   = 1'b1;
               w_cntNext   = CNT_W'(1);
               w_stateNext = IDLE;
            end
         end
         LOW: begin
            if (w_rise) begin
               w_report    = 1'b1;
               w_cntNext   = CNT_W'(1);
               w_stateNext = HIGH;
            end else if (r_cnt == MAX_CNT) begin
               w_timeout   = 1'b1;
               w_cntNext   = CNT_W'(1);
               w_stateNext = IDLE;
            end
         end
         default: begin
            w_stateNext = IDLE;
         end
      endcase
   end

   always_ff @(posedge s_clk or negedge s_rst) begin
      if (!s_rst) begin
         r_cnt       <= '0;
         r_hcnt      <= '0;
         r_period    <= '0;
         r_highTime  <= '0;
         r_measValid <= 1'b0;
         r_timeout   <= 1'b0;
      end else begin
         r_cnt       <= w_cntNext;
         r_hcnt      <= w_hcntNext;
         r_measValid <= w_report;
         r_timeout   <= w_timeout;
         if (w_report) begin
            r_period   <= r_cnt;
            r_highTime <= r_hcnt;
         end
      end
   end

   assign period     = r_period;
   assign high_time  = r_highTime;
   assign meas_valid = r_measValid;
   assign timeout    = r_timeout;
   assign pwm_level  = w_level;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: table of duty/period vectors plus reset, timeout and glitch sequences.
// Build with or without PWM_CAPTURE_FILTER_EN; the tables and latencies follow that macro.
module tb_pwm_capture;

   localparam int CW   = 16;
   localparam int MAXP = 40;
`ifdef PWM_CAPTURE_FILTER_EN
   localparam int LAT = 7;
   localparam int TH  = 4;
   localparam int TL  = 6;
`else
   localparam int LAT = 3;
   localparam int TH  = 3;
   localparam int TL  = 5;
`endif

   typedef struct {
      int hiLen;
      int loLen;
      int expPer;
      int expHi;
   } vec_t;

   typedef struct {
      int per;
      int hi;
   } report_t;

   logic          s_clk;
   logic          s_rst;
   logic          pwm_in;
   logic [CW-1:0] period;
   logic [CW-1:0] high_time;
   logic          meas_valid;
   logic          timeout;
   logic          pwm_level;

   int      compared;
   int      mismatched;
   vec_t    vecs[$];
   report_t reports[$];
   report_t rep;

   pwm_capture #(
      .CNT_W      (CW),
      .MAX_PERIOD (MAXP)
`ifdef PWM_CAPTURE_FILTER_EN
      ,
      .FILT_LEN   (4)
`endif
   ) dut (
      .s_clk      (s_clk),
      .s_rst      (s_rst),
      .pwm_in     (pwm_in),
      .period     (period),
      .high_time  (high_time),
      .meas_valid (meas_valid),
      .timeout    (timeout),
      .pwm_level  (pwm_level)
   );

   initial s_clk = 1'b0;
   always #5 s_clk = ~s_clk;

   // Every report is captured away from the active edge for later checking.
   always @(negedge s_clk) begin
      if (s_rst && meas_valid) begin
         rep.per = int'(period);
         rep.hi  = int'(high_time);
         reports.push_back(rep);
      end
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic level, input int cycles);
      pwm_in = level;
      repeat (cycles) @(negedge s_clk);
   endtask

   task automatic runPeriods(input int hi, input int lo, input int n);
      for (int k = 0; k < n; k++) begin
         applyStimulus(1'b1, hi);
         applyStimulus(1'b0, lo);
      end
   endtask

   task automatic doReset();
      s_rst  = 1'b0;
      pwm_in = 1'b0;
      repeat (3) @(negedge s_clk);
      s_rst = 1'b1;
      reports.delete();
   endtask

   task automatic waitTimeout(input int budget, output int cycles);
      cycles = 0;
      do begin
         @(negedge s_clk);
         cycles++;
      end while (!timeout && cycles < budget);
      if (!timeout) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL timeout wait: no pulse within %0d cycles", budget);
      end
   endtask

   initial begin
      int c;
      compared   = 0;
      mismatched = 0;
      s_rst      = 1'b0;
      pwm_in     = 1'b0;

`ifdef PWM_CAPTURE_FILTER_EN
      vecs.push_back('{4, 4, 8, 4});
      vecs.push_back('{5, 5, 10, 5});
      vecs.push_back('{4, 6, 10, 4});
      vecs.push_back('{6, 4, 10, 6});
      vecs.push_back('{10, 20, 30, 10});
`else
      vecs.push_back('{3, 5, 8, 3});
      vecs.push_back('{1, 7, 8, 1});
      vecs.push_back('{2, 6, 8, 2});
      vecs.push_back('{4, 4, 8, 4});
      vecs.push_back('{5, 3, 8, 5});
      vecs.push_back('{6, 2, 8, 6});
      vecs.push_back('{7, 1, 8, 7});
      vecs.push_back('{10, 20, 30, 10});
`endif

      repeat (2) @(negedge s_clk);
      checkOutput("reset period", int'(period), 0);
      checkOutput("reset high_time", int'(high_time), 0);
      checkOutput("reset meas_valid", int'(meas_valid), 0);
      checkOutput("reset timeout", int'(timeout), 0);
      checkOutput("reset pwm_level", int'(pwm_level), 0);

      // Four PWM cycles give three reports: the first rise is never reported.
      for (int v = 0; v < vecs.size(); v++) begin
         doReset();
         runPeriods(vecs[v].hiLen, vecs[v].loLen, 4);
         applyStimulus(1'b0, LAT + 5);
         checkOutput($sformatf("vec%0d report count", v), reports.size(), 3);
         for (int r = 0; r < reports.size(); r++) begin
            checkOutput($sformatf("vec%0d rep%0d period", v, r), reports[r].per, vecs[v].expPer);
            checkOutput($sformatf("vec%0d rep%0d high_time", v, r), reports[r].hi, vecs[v].expHi);
         end
      end

      // Reset while in HIGH clears outputs at once and discards the measurement in flight.
      doReset();
      runPeriods(TH, TL, 3);
      applyStimulus(1'b1, LAT + 2);
      checkOutput("pre-reset report count", reports.size(), 3);
      checkOutput("pre-reset pwm_level", int'(pwm_level), 1);
      s_rst = 1'b0;
      #1;
      checkOutput("mid-reset period", int'(period), 0);
      checkOutput("mid-reset high_time", int'(high_time), 0);
      checkOutput("mid-reset meas_valid", int'(meas_valid), 0);
      checkOutput("mid-reset timeout", int'(timeout), 0);
      checkOutput("mid-reset pwm_level", int'(pwm_level), 0);
      pwm_in = 1'b0;
      repeat (2) @(negedge s_clk);
      s_rst = 1'b1;
      reports.delete();
      runPeriods(TH, TL, 1);
      checkOutput("after reset first rise reports", reports.size(), 0);
      runPeriods(TH, TL, 2);
      applyStimulus(1'b0, LAT + 5);
      checkOutput("after reset report count", reports.size(), 2);
      if (reports.size() > 0) begin
         checkOutput("after reset period", reports[0].per, TH + TL);
         checkOutput("after reset high_time", reports[0].hi, TH);
      end

      // Constant low: timeouts MAX_PERIOD apart, never a report.
      doReset();
      waitTimeout(MAXP + 20, c);
      checkOutput("low first timeout cycles", c, MAXP + 1);
      waitTimeout(MAXP + 20, c);
      checkOutput("low repeat timeout cycles", c, MAXP);
      checkOutput("low pwm_level", int'(pwm_level), 0);
      checkOutput("low report count", reports.size(), 0);
      checkOutput("low period", int'(period), 0);

      // Stuck high after running cycles: timeout, level 1, last measurement held.
      doReset();
      runPeriods(TH, TL, 3);
      pwm_in = 1'b1;
      waitTimeout(MAXP + LAT + 20, c);
      checkOutput("high timeout cycles", c, MAXP + LAT + 1);
      checkOutput("high report count", reports.size(), 3);
      checkOutput("high pwm_level", int'(pwm_level), 1);
      checkOutput("high held period", int'(period), TH + TL);
      checkOutput("high held high_time", int'(high_time), TH);

      // 10/20 waveform with a 2-cycle glitch inside the low phase.
      doReset();
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b1, 10);
         applyStimulus(1'b0, 5);
         applyStimulus(1'b1, 2);
         applyStimulus(1'b0, 13);
      end
      applyStimulus(1'b0, LAT + 5);
`ifdef PWM_CAPTURE_FILTER_EN
      checkOutput("glitch report count", reports.size(), 2);
      for (int r = 0; r < reports.size(); r++) begin
         checkOutput($sformatf("glitch rep%0d period", r), reports[r].per, 30);
         checkOutput($sformatf("glitch rep%0d high_time", r), reports[r].hi, 10);
      end
`else
      checkOutput("glitch report count", reports.size(), 5);
      if (reports.size() >= 2) begin
         checkOutput("glitch rep0 period", reports[0].per, 15);
         checkOutput("glitch rep0 high_time", reports[0].hi, 10);
         checkOutput("glitch rep1 period", reports[1].per, 15);
         checkOutput("glitch rep1 high_time", reports[1].hi, 2);
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
